// File: rtl/pe_packet_rx_if.sv
// Packet-in / result-out handshake bundle for the PE receiver.
// in_* flows toward the PE, out_* flows away from it.
interface pe_packet_rx_if;
  logic [29:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [29:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        err_addr;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, err_addr
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, err_addr
  );
endinterface

// File: rtl/pe_packet_rx.sv
// Processing element receiver: collects five 8-bit weights and a 25-bit spike
// vector, then streams 21 sliding-window partial sums as result packets.
module pe_packet_rx #(
  parameter logic [3:0] PE_ADDR   = 4'd5,
  parameter logic [3:0] DEST_ADDR = 4'd0
) (
  input logic          clk,
  input logic          reset,
  pe_packet_rx_if.slave bus
);

  typedef enum logic {ACCEPT, SEND} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  wcnt_reg;
  logic [7:0]  w_reg [5];
  logic [24:0] spikes_reg;
  logic        pending_reg;
  logic [4:0]  j_reg;
  logic        err_reg;

  logic        in_fire;
  logic        out_fire;
  logic        addr_hit;
  logic        is_input;
  logic [10:0] term [5];
  logic [10:0] psum;

  assign in_fire  = bus.in_valid && (state_reg == ACCEPT);
  assign out_fire = bus.out_valid && bus.out_ready;
  assign addr_hit = (bus.in_data[29:26] == PE_ADDR);
  assign is_input = bus.in_data[25];

  // One gated weight per tap of the 5-wide window starting at spike j.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_tap
      assign term[gi] = spikes_reg[5'(j_reg + 5'(gi))] ? {3'b000, w_reg[gi]} : 11'd0;
    end
  endgenerate

  always_comb begin
    psum = 11'd0;
    for (int k = 0; k < 5; k++) begin
      psum = psum + term[k];
    end
  end

  assign bus.in_ready  = (state_reg == ACCEPT);
  assign bus.out_valid = (state_reg == SEND);
  assign bus.out_data  = (state_reg == SEND) ?
                         {DEST_ADDR, 1'b0, j_reg, 9'd0, psum} : 30'd0;
  assign bus.err_addr  = err_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCEPT: begin
        if (in_fire && addr_hit) begin
          if (is_input && wcnt_reg == 3'd5) begin
            state_next = SEND;
          end else if (!is_input && wcnt_reg == 3'd3 && pending_reg) begin
            state_next = SEND;
          end
        end
      end
      SEND: begin
        if (out_fire && j_reg == 5'd20) begin
          state_next = ACCEPT;
        end
      end
      default: state_next = ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ACCEPT;
      wcnt_reg    <= 3'd0;
      spikes_reg  <= 25'd0;
      pending_reg <= 1'b0;
      j_reg       <= 5'd0;
      err_reg     <= 1'b0;
      for (int k = 0; k < 5; k++) begin
        w_reg[k] <= 8'd0;
      end
    end else begin
      state_reg <= state_next;
      err_reg   <= in_fire && !addr_hit;

      if (in_fire && addr_hit) begin
        if (is_input) begin
          spikes_reg <= bus.in_data[24:0];
          if (wcnt_reg != 3'd5) begin
            pending_reg <= 1'b1;
          end
        end else if (wcnt_reg == 3'd3) begin
          // Second weight packet: low byte carries no weight.
          w_reg[3] <= bus.in_data[23:16];
          w_reg[4] <= bus.in_data[15:8];
          wcnt_reg <= 3'd5;
        end else begin
          // Empty or already full: start a fresh weight set.
          w_reg[0] <= bus.in_data[23:16];
          w_reg[1] <= bus.in_data[15:8];
          w_reg[2] <= bus.in_data[7:0];
          wcnt_reg <= 3'd3;
        end
      end

      if (state_reg == ACCEPT && state_next == SEND) begin
        j_reg <= 5'd0;
      end else if (state_reg == SEND && out_fire) begin
        if (j_reg == 5'd20) begin
          j_reg       <= 5'd0;
          pending_reg <= 1'b0;
        end else begin
          j_reg <= j_reg + 5'd1;
        end
      end
    end
  end

endmodule

// File: doc/pe_packet_rx.md
PE_PACKET_RX -- requirements
Module: pe_packet_rx

Interface
REQ-001 Parameter PE_ADDR, default 5: this PE's 4-bit address; packets with in_data[29:26] equal to it are consumed.
REQ-002 Parameter DEST_ADDR, default 0: 4-bit address placed in out_data[29:26] of every result packet.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  30  packet: [29:26] address, [25] opcode (0 weight, 1 input), [24:0] payload.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  block can accept a packet this cycle.
REQ-008 out_data  output  30  result packet.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 out_ready  input  1  downstream accepts out_data.
REQ-011 err_addr  output  1  one-cycle pulse on a consumed packet with a foreign address.

Function
REQ-012 Handshake: a transfer occurs on any rising edge where valid and ready are both 1; out_data/out_valid SHALL hold stable until transferred.
REQ-013 FSM states: ACCEPT and SEND; in_ready = 1 only in ACCEPT.
REQ-014 Address mismatch in ACCEPT: packet consumed, discarded, err_addr = 1 the following cycle, no state change.
REQ-015 Weight packet (opcode 0), wcnt = 0: w0..w2 <= [23:16], [15:8], [7:0]; wcnt <= 3.
REQ-016 Weight packet, wcnt = 3: w3 <= [23:16], w4 <= [15:8], [7:0] discarded; wcnt <= 5 (weights full).
REQ-017 Weight packet, wcnt = 5: treated as wcnt = 0 (reload; w0..w2 overwritten, wcnt <= 3).
REQ-018 Input packet (opcode 1): spikes[24:0] <= in_data[24:0]; if wcnt = 5, go to SEND with j = 0; otherwise stay in ACCEPT with input_pending set.
REQ-019 Weight packet completing wcnt = 5 while input_pending is set: go to SEND with j = 0 next cycle.
REQ-020 Input packet arriving while input_pending is set overwrites spikes (latest wins).
REQ-021 SEND: psum(j) = sum over k = 0..4 of (spikes[j+k] ? wk : 0), unsigned, 11 bits, no overflow possible.
REQ-022 out_data = {DEST_ADDR, 1'b0, j[4:0], 9'b0, psum(j)}; out_valid = 1 throughout SEND.
REQ-023 On out transfer: if j < 20, j <= j+1; if j = 20, clear input_pending, return to ACCEPT; weights and wcnt retained.
REQ-024 Latency: out_valid rises the cycle after the triggering input/weight transfer; with out_ready held high, the 21 results occupy 21 consecutive cycles.
REQ-025 in_valid during SEND SHALL be ignored (no transfer since in_ready = 0).

Reset
REQ-026 reset SHALL force ACCEPT, wcnt = 0, w0..w4 = 0, spikes = 0, input_pending = 0, j = 0, out_valid = 0, out_data = 0, err_addr = 0, in_ready = 1 the cycle after release.
REQ-027 reset mid-SEND SHALL abort: the remaining results are never emitted, and reloading both weight packets is required.

Verification
REQ-028 Weights {0,1,2} then {3,4,x}, input 25'h1FFFFFF -> 21 packets, j = 0..20, psum = 10 each, out_data[29:26] = 0.
REQ-029 Same weights, input bit i = i&1 (25'h0AAAAAA) -> psum = 4 for even j, 6 for odd j.
REQ-030 Input sent before any weights, then both weight packets -> no output until the second weight transfer, then j = 0 next cycle.
REQ-031 Packet with address 3 -> err_addr pulse, no weight/input change, no output.
REQ-032 out_ready held low 5 cycles at j = 7 -> out_data unchanged during stall; in_ready stays 0; sequence resumes at j = 7.
REQ-033 reset asserted at j = 10 -> out_valid = 0 next cycle; a subsequent input without reloaded weights produces no output.
